// File: rtl/cic_dec_ctrl_if.sv
// Handshake/bus bundle between the CIC decimator sequencer and its host.
// The slave modport is the sequencer; the master modport is the host side
// (filter datapath, sample consumer, control registers).
// Optional macro CIC_NORM_EN adds the norm_shift control input.
interface cic_dec_ctrl_if #(
    parameter int RW = 16,
    parameter int DW = 24
);
    logic          enable;
    logic          ratio_wr;
    logic [RW-1:0] ratio_in;
    logic [DW-1:0] cic_out;
    logic          dec_stb;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic          ovr_clr;
    logic [1:0]    state;
`ifdef CIC_NORM_EN
    logic [4:0]    norm_shift;
`endif

    modport master (
        output enable, ratio_wr, ratio_in, cic_out, out_ready, ovr_clr,
`ifdef CIC_NORM_EN
        output norm_shift,
`endif
        input  dec_stb, out_data, out_valid, overrun, state
    );

    modport slave (
        input  enable, ratio_wr, ratio_in, cic_out, out_ready, ovr_clr,
`ifdef CIC_NORM_EN
        input  norm_shift,
`endif
        output dec_stb, out_data, out_valid, overrun, state
    );
endinterface

// File: rtl/cic_dec_ctrl.sv
// Sequencer for a 3-stage CIC decimator: generates the decimation strobe
// from a programmable ratio, discards the start-up transient after enable
// or a ratio change, and captures settled samples into a valid/ready
// output register with sticky overrun detection.
// Optional macro CIC_NORM_EN: arithmetic right shift of captured samples
// by a norm_shift value latched at start / ratio apply.
module cic_dec_ctrl #(
    parameter int RW             = 16,
    parameter int DW             = 24,
    parameter int SETTLE_SAMPLES = 3,
    parameter int CAP_DLY        = 1
) (
    input  logic          clk,
    input  logic          rst,
    cic_dec_ctrl_if.slave bus
);
    localparam int SW = $clog2(SETTLE_SAMPLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETTLE = 2'b01,
        S_RUN    = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] ratio_q, ratio_d;
    logic [RW-1:0] pend_val_q, pend_val_d;
    logic          pend_q, pend_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          dec_stb_q, dec_stb_d;
    logic [CAP_DLY-1:0] cap_sr_q, cap_sr_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          overrun_q, overrun_d;

    logic          running;
    logic          active;
    logic          wrap;
    logic          apply;
    logic          cap_stb;
    logic          settle_done;
    logic [RW-1:0] ratio_clamped;
    logic [DW-1:0] cap_val;

    assign active        = running && bus.enable;
    assign wrap          = (cnt_q == ratio_q - RW'(1));
    assign apply         = active && dec_stb_q && pend_q;
    assign cap_stb       = cap_sr_q[CAP_DLY-1];
    assign settle_done   = (settle_q == SW'(SETTLE_SAMPLES - 1));
    assign ratio_clamped = (bus.ratio_in < RW'(2)) ? RW'(2) : bus.ratio_in;

`ifdef CIC_NORM_EN
    logic [4:0] shift_q, shift_d;

    // Latch the gain-compensation shift when a new ratio takes effect.
    always_comb begin
        shift_d = shift_q;
        if ((state_q == S_IDLE && bus.enable) || apply) begin
            shift_d = (bus.norm_shift > 5'(DW - 1)) ? 5'(DW - 1) : bus.norm_shift;
        end
        cap_val = $signed(bus.cic_out) >>> shift_q;
    end

    // Shift register, cleared to pass-through on reset.
    always_ff @(posedge clk) begin
        if (!rst) shift_q <= '0;
        else      shift_q <= shift_d;
    end
`else
    assign cap_val = bus.cic_out;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state: start, settle-count completion, ratio apply, disable.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of
        // inferred latches on paths that do not change state.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.enable) state_d = S_SETTLE;
            S_SETTLE: begin
                if (!bus.enable)                 state_d = S_IDLE;
                else if (apply)                  state_d = S_SETTLE;
                else if (cap_stb && settle_done) state_d = S_RUN;
            end
            S_RUN: begin
                if (!bus.enable) state_d = S_IDLE;
                else if (apply)  state_d = S_SETTLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: run qualifier and state code.
    always_comb begin
        running   = (state_q != S_IDLE);
        bus.state = state_q;
    end

    // Datapath next-state: ratio counter, strobe, capture line, output register.
    always_comb begin
        cnt_d       = '0;
        dec_stb_d   = active && wrap;
        cap_sr_d    = '0;
        settle_d    = '0;
        ratio_d     = ratio_q;
        pend_d      = pend_q;
        pend_val_d  = pend_val_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q && !bus.ovr_clr;

        if (active) begin
            cnt_d    = (apply || wrap) ? '0 : cnt_q + RW'(1);
            cap_sr_d = (cap_sr_q << 1) | CAP_DLY'(dec_stb_q);
            if (apply)                                 settle_d = '0;
            else if (state_q == S_SETTLE && cap_stb)   settle_d = settle_q + SW'(1);
            else                                       settle_d = settle_q;
        end

        // Ratio: direct load while stopped, pending otherwise; a disable
        // flushes any pending value into ratio_reg.
        if (!running) begin
            if (bus.ratio_wr) ratio_d = ratio_clamped;
        end else if (!bus.enable) begin
            pend_d = 1'b0;
            if (bus.ratio_wr)  ratio_d = ratio_clamped;
            else if (pend_q)   ratio_d = pend_val_q;
        end else begin
            if (apply) begin
                ratio_d = pend_val_q;
                pend_d  = 1'b0;
            end
            if (bus.ratio_wr) begin
                pend_val_d = ratio_clamped;
                pend_d     = 1'b1;
            end
        end

        // Output register: capture settled samples, drop on backpressure.
        if (!active) begin
            out_valid_d = 1'b0;
        end else if (state_q == S_RUN && cap_stb) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d  = cap_val;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            ratio_q     <= RW'(2);
            pend_q      <= 1'b0;
            pend_val_q  <= RW'(2);
            settle_q    <= '0;
            dec_stb_q   <= 1'b0;
            // NOTE: the capture delay line is reset explicitly so a strobe
            // in flight at reset can never produce a stray capture.
            cap_sr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ratio_q     <= ratio_d;
            pend_q      <= pend_d;
            pend_val_q  <= pend_val_d;
            settle_q    <= settle_d;
            dec_stb_q   <= dec_stb_d;
            cap_sr_q    <= cap_sr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.dec_stb   = dec_stb_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: doc/cic_dec_ctrl.md
Name: cic_dec_ctrl

Overview:
- Sequencer for the 3-stage CIC decimator.
- Generates the decimation strobe that drives the differentiator's decimation clock input (`dec_clk`) from a programmable ratio R.
- Discards the filter's start-up transient after enable or a ratio change.
- Captures each settled 24-bit decimated sample into a valid/ready output register with overrun detection.

Parameters:
- RW, 16, width of decimation-ratio field.
- DW, 24, width of CIC output sample.
- SETTLE_SAMPLES, 3, decimated samples discarded after start or ratio change (matches filter order).
- CAP_DLY, 1, clk cycles from `dec_stb` to capture of `cic_out` (differentiator output latency); legal 1..4.

Ports:
- clk  in  1  system clock, same clock as the CIC integrators.
- rst  in  1  synchronous reset, active-low.
- enable  in  1  run request; low forces IDLE.
- ratio_wr  in  1  one-cycle write strobe for `ratio_in`.
- ratio_in  in  RW  requested decimation ratio R.
- cic_out  in  DW  CIC differentiator output.
- dec_stb  out  1  one-clk-wide decimation strobe, routed to CIC `dec_clk`.
- out_data  out  DW  captured decimated sample.
- out_valid  out  1  `out_data` holds an unconsumed sample.
- out_ready  in  1  consumer accepts `out_data` when `out_valid` & `out_ready`.
- overrun  out  1  sticky: a settled sample was dropped.
- ovr_clr  in  1  clears `overrun`.
- state  out  2  00 IDLE, 01 SETTLE, 10 RUN.

Behaviour:
- Reset (`rst`=0 at a clk edge): state=IDLE; cnt=0; ratio_reg=2; pending=0; settle_cnt=0; dec_stb=0; out_data=0; out_valid=0; overrun=0. The capture delay line clears; any in-flight capture is lost.
- Ratio write:
  - `ratio_in`<2 is clamped to 2.
  - In IDLE, the write loads ratio_reg directly.
  - Otherwise the value latches into a pending register and pending=1. A second write before apply overwrites it (last write wins).
  - Pending applies on the cycle `dec_stb` is asserted: ratio_reg updates, cnt restarts at 0 next cycle, state goes to SETTLE with settle_cnt=0.
- Counter: in SETTLE/RUN, cnt increments each clk and wraps at ratio_reg-1. `dec_stb`=1 exactly in the cycle after cnt==ratio_reg-1, so `dec_stb` has period R clk with 1-cycle width. The first strobe comes R cycles after entering SETTLE from IDLE.
- Capture: the delay line delays `dec_stb` by CAP_DLY cycles to form cap_stb. On cap_stb, `cic_out` is sampled.
- States:
  - IDLE: no strobes. `enable`=1 → SETTLE, cnt=0, settle_cnt=0.
  - SETTLE: each cap_stb increments settle_cnt and discards the sample. When settle_cnt reaches SETTLE_SAMPLES → RUN. No `out_valid`, no overrun.
  - RUN: each cap_stb is a settled sample.
  - SETTLE/RUN with `enable`=0 → IDLE next cycle. cnt=0, pending applied to ratio_reg, capture pipeline flushed, `out_valid` cleared, `out_data` held.
- Output register (RUN):
  - cap_stb with `out_valid`=0, or with `out_valid`=1 and `out_ready`=1 in the same cycle: `out_data`←`cic_out`, `out_valid`=1.
  - cap_stb with `out_valid`=1 and `out_ready`=0: new sample dropped, `out_data` kept, `overrun`←1.
  - Handshake without cap_stb: `out_valid`←0 next cycle.
- Overrun: `overrun` set and `ovr_clr` in the same cycle → `overrun` stays 1 (set wins).
- Minimum R=2 guarantees one idle clk between strobes.

Optional Feature:
- Macro CIC_NORM_EN.
- Defined: adds input `norm_shift` [4:0]. `out_data` = `cic_out` arithmetically right-shifted by `norm_shift` at capture, to compensate the R^3 gain. `norm_shift` is sampled only at ratio apply or IDLE→SETTLE and held otherwise; values >23 saturate to 23.
- Not defined: port absent; `out_data` = `cic_out` unmodified.

Test Plan:
- Reset then `enable`=1, R=2 default, `out_ready`=1 → `dec_stb` every 2 clk; first 3 captures discarded; `state`=10 after 3rd cap_stb; `out_valid` pulses on 4th capture, `out_data`=`cic_out` at cap_stb.
- Write `ratio_in`=16 in IDLE, enable → `dec_stb` period exactly 16 clk; write `ratio_in`=0 → ratio_reg=2.
- In RUN with R=8, write 32 then 64 mid-period → only 64 applied at next `dec_stb`; `state` returns to 01 for 3 samples; subsequent strobes spaced 64.
- RUN, `out_ready`=0 for two captures → first held in `out_data`, second dropped, `overrun`=1; `ovr_clr` pulse → 0; `ovr_clr` coincident with new overrun → stays 1.
- Drop `enable` mid-period with `out_valid`=1 → next cycle `state`=00, `out_valid`=0, no further `dec_stb`; assert `rst`=0 during RUN → all outputs at reset values next edge.
- CIC_NORM_EN, `norm_shift`=9, `cic_out`=0x040000 → `out_data`=0x000200; `norm_shift`=31 on 0x800000 → 0xFFFFFF.
